uart_reg_responder: RTL

Byte-level command responder on the synchronous side of the UART pin converter: consumes received bytes over the RX strobe/acknowledge handshake, decodes register read/write commands, drives a simple register bus, and returns one reply byte per command over the TX strobe/acknowledge handshake. It is the host-side peer of the UART converter and the bridge between a PC terminal and on-chip control registers.

---
 rtl/uart_reg_responder_if.sv | 39 +++
 rtl/uart_reg_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_reg_responder_if
//  Purpose  : Byte handshake (RX/TX) and register bus bundle between the
//             UART command responder (slave) and its environment (master:
//             UART pin converter plus register file).
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_reg_responder_if #(
  parameter int ADDR_W = 4
);
  // Received byte path: converter -> responder
  logic              rx_stb;
  logic [7:0]        rx_dat;
  logic              rx_ack;
  // Reply byte path: responder -> converter
  logic              tx_stb;
  logic [7:0]        tx_dat;
  logic              tx_ack;
  logic              tx_rdy;
  // Register bus
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdat;
  logic [7:0]        reg_rdat;

  // Environment side: converter and register file
  modport master (
    output rx_stb, rx_dat, tx_ack, tx_rdy, reg_rdat,
    input  rx_ack, tx_stb, tx_dat, reg_we, reg_addr, reg_wdat
  );

  // Responder side
  modport slave (
    input  rx_stb, rx_dat, tx_ack, tx_rdy, reg_rdat,
    output rx_ack, tx_stb, tx_dat, reg_we, reg_addr, reg_wdat
  );
endinterface
`default_nettype wire

// File: rtl/uart_reg_responder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_reg_responder
//  Purpose  : Decodes 'W' addr data / 'R' addr byte commands arriving over
//             the RX strobe/ack handshake, drives a simple register bus and
//             returns one reply byte per command over the TX handshake.
//  Options  : RESP_TIMEOUT_EN - when defined, a partially received command
//             is abandoned after TIMEOUT_CYC idle cycles (counted as error).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_reg_responder #(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  wire                 clk,
  input  wire                 rst_n,
  uart_reg_responder_if.slave bus,
  output logic                busy,
  output logic [7:0]          err_cnt
);

  // Command and reply byte codes
  localparam logic [7:0] c_cmd_write = 8'h57;  // 'W'
  localparam logic [7:0] c_cmd_read  = 8'h52;  // 'R'
  localparam logic [7:0] c_rsp_ok    = 8'h4B;  // 'K'
  localparam logic [7:0] c_rsp_err   = 8'h3F;  // '?'

  // FSM encoding
  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_get_addr = 3'd1;
  localparam logic [2:0] c_st_get_data = 3'd2;
  localparam logic [2:0] c_st_exec     = 3'd3;
  localparam logic [2:0] c_st_send     = 3'd4;
  localparam logic [2:0] c_st_wait_ack = 3'd5;

  // Reject impossible configurations at elaboration
  if (ADDR_W < 1 || ADDR_W > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_reg_responder: ADDR_W must be 1..8 and TIMEOUT_CYC >= 1");
  end

  logic [2:0]        state_q,    state_d;
  logic              armed_q,    armed_d;     // RX_STB seen low since last ack
  logic              rx_ack_q,   rx_ack_d;
  logic              is_wr_q,    is_wr_d;     // current command is a write
  logic              tx_stb_q,   tx_stb_d;
  logic [7:0]        tx_dat_q,   tx_dat_d;
  logic [7:0]        reply_q,    reply_d;     // reply parked while TX busy
  logic              reg_we_q,   reg_we_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdat_q, reg_wdat_d;
  logic [7:0]        err_cnt_q,  err_cnt_d;

  logic              w_accept;
  logic              w_addr_bad;
  logic              w_err_inc;
  logic              w_launch;
  logic [7:0]        w_launch_dat;

`ifdef RESP_TIMEOUT_EN
  localparam int                c_tmo_w   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT_CYC);
  logic [c_tmo_w-1:0] tmo_q, tmo_d;
`endif

  // A byte is taken only in the receiving states and only once per strobe
  assign w_accept = bus.rx_stb && armed_q &&
                    ((state_q == c_st_idle) ||
                     (state_q == c_st_get_addr) ||
                     (state_q == c_st_get_data));

  // Any address bit at or above ADDR_W makes the address unreachable
  assign w_addr_bad = ((bus.rx_dat >> ADDR_W) != 8'd0);

  // Next-state, handshake and register bus decode
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    rx_ack_d     = 1'b0;
    is_wr_d      = is_wr_q;
    tx_stb_d     = tx_stb_q;
    tx_dat_d     = tx_dat_q;
    reply_d      = reply_q;
    reg_we_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdat_d   = reg_wdat_q;
    err_cnt_d    = err_cnt_q;
    w_err_inc    = 1'b0;
    w_launch     = 1'b0;
    w_launch_dat = reply_q;
`ifdef RESP_TIMEOUT_EN
    tmo_d        = '0;
`endif

    // The converter holds STB for a cycle after our ack; wait for it to drop
    if (!bus.rx_stb) begin
      armed_d = 1'b1;
    end
    if (w_accept) begin
      armed_d  = 1'b0;
      rx_ack_d = 1'b1;
    end

    case (state_q)
      c_st_idle: begin
        if (w_accept) begin
          if (bus.rx_dat == c_cmd_write) begin
            is_wr_d = 1'b1;
            state_d = c_st_get_addr;
          end else if (bus.rx_dat == c_cmd_read) begin
            is_wr_d = 1'b0;
            state_d = c_st_get_addr;
          end else begin
            w_err_inc    = 1'b1;
            w_launch     = 1'b1;
            w_launch_dat = c_rsp_err;
          end
        end
      end
      c_st_get_addr: begin
        if (w_accept) begin
          if (w_addr_bad) begin
            w_err_inc    = 1'b1;
            w_launch     = 1'b1;
            w_launch_dat = c_rsp_err;
          end else begin
            reg_addr_d = bus.rx_dat[ADDR_W-1:0];
            state_d    = is_wr_q ? c_st_get_data : c_st_exec;
          end
        end
      end
      c_st_get_data: begin
        if (w_accept) begin
          // Strobe is registered so it is high exactly during the EXEC cycle
          reg_wdat_d = bus.rx_dat;
          reg_we_d   = 1'b1;
          state_d    = c_st_exec;
        end
      end
      c_st_exec: begin
        // Read data is taken at the end of EXEC, with REG_ADDR settled
        w_launch     = 1'b1;
        w_launch_dat = is_wr_q ? c_rsp_ok : bus.reg_rdat;
      end
      c_st_send: begin
        if (bus.tx_rdy) begin
          tx_stb_d = 1'b1;
          tx_dat_d = reply_q;
          state_d  = c_st_wait_ack;
        end
      end
      c_st_wait_ack: begin
        if (bus.tx_ack) begin
          tx_stb_d = 1'b0;
          state_d  = c_st_idle;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase

    // Reply launch: SEND is only occupied while the transmitter is busy;
    // with TX_RDY high the strobe rises on the very edge that leaves EXEC
    // (or the rejecting state), giving the minimum reply latency.
    if (w_launch) begin
      if (bus.tx_rdy) begin
        tx_stb_d = 1'b1;
        tx_dat_d = w_launch_dat;
        state_d  = c_st_wait_ack;
      end else begin
        reply_d  = w_launch_dat;
        state_d  = c_st_send;
      end
    end

`ifdef RESP_TIMEOUT_EN
    // Inter-byte watchdog while a command is partially received
    if ((state_q == c_st_get_addr) || (state_q == c_st_get_data)) begin
      if (w_accept) begin
        tmo_d = '0;
      end else if (tmo_q == c_tmo_max) begin
        tmo_d     = '0;
        w_err_inc = 1'b1;
        state_d   = c_st_idle;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    // Saturating error counter
    if (w_err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= c_st_idle;
      armed_q    <= 1'b1;
      rx_ack_q   <= 1'b0;
      is_wr_q    <= 1'b0;
      tx_stb_q   <= 1'b0;
      tx_dat_q   <= 8'h00;
      reply_q    <= 8'h00;
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_wdat_q <= 8'h00;
      err_cnt_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      rx_ack_q   <= rx_ack_d;
      is_wr_q    <= is_wr_d;
      tx_stb_q   <= tx_stb_d;
      tx_dat_q   <= tx_dat_d;
      reply_q    <= reply_d;
      reg_we_q   <= reg_we_d;
      reg_addr_q <= reg_addr_d;
      reg_wdat_q <= reg_wdat_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

`ifdef RESP_TIMEOUT_EN
  // Inter-byte timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  // No watchdog: GET_ADDR/GET_DATA wait indefinitely for the next byte
`endif

  assign bus.rx_ack   = rx_ack_q;
  assign bus.tx_stb   = tx_stb_q;
  assign bus.tx_dat   = tx_dat_q;
  assign bus.reg_we   = reg_we_q;
  assign bus.reg_addr = reg_addr_q;
  assign bus.reg_wdat = reg_wdat_q;
  assign busy         = (state_q != c_st_idle);
  assign err_cnt      = err_cnt_q;

endmodule
`default_nettype wire
